crc_frame_scheduler: RTL and testbench

Shares one multi-word parallel CRC datapath between NUM_REQ requesters. Each requester streams a frame of DWIDTH-bit words over valid/ready with a last flag. Frames are granted round-robin and processed at one word per cycle, carrying the running remainder across words. Init, reflect-in, reflect-out and final-XOR are applied, and the CRC is returned tagged with the requester id. Sits between DMA/packet clients and the CRC result consumer.

---
 rtl/crc_sched_pkg.sv | 34 +++
 rtl/crc_word_step.sv | 24 ++
 rtl/crc_frame_scheduler.sv | 174 +++++++++++++++++
 tb/tb_crc_frame_scheduler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_sched_pkg.sv
// Shared types and bit-ordering helpers for the CRC frame scheduler.
package crc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    // Helpers work on wide containers; callers cast to their real widths.
    localparam int MAX_DW = 512;
    localparam int MAX_CW = 64;

    function automatic logic [MAX_DW-1:0] byte_reflect(input logic [MAX_DW-1:0] w);
        logic [MAX_DW-1:0] r;
        for (int b = 0; b < MAX_DW / 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[b*8+i] = w[b*8+7-i];
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_CW-1:0] bit_reverse(input logic [MAX_CW-1:0] v, input int width);
        logic [MAX_CW-1:0] r;
        for (int i = 0; i < MAX_CW; i++) begin
            r[i] = v[MAX_CW-1-i];
        end
        return r >> (MAX_CW - width);
    endfunction

endpackage

// File: rtl/crc_word_step.sv
// Combinational CRC update over one DWIDTH-bit word, MSB first.
module crc_word_step #(
    parameter int CRC_WIDTH = 16,
    parameter int DWIDTH    = 32
) (
    input  logic [CRC_WIDTH-1:0] crcIn,
    input  logic [DWIDTH-1:0]    data,
    input  logic [CRC_WIDTH-1:0] poly,
    output logic [CRC_WIDTH-1:0] crcOut
);

    always_comb begin
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c  = crcIn;
        fb = 1'b0;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ data[i];
            c  = (c << 1) ^ (fb ? poly : '0);
        end
        crcOut = c;
    end

endmodule

// File: rtl/crc_frame_scheduler.sv
// Round-robin scheduler sharing one word-parallel CRC engine among NUM_REQ frame streams.
// Optional idle-frame abort is enabled by defining CRC_TIMEOUT_EN.
module crc_frame_scheduler
    import crc_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int CRC_WIDTH      = 16,
    parameter int DWIDTH         = 32,
    parameter int REQ_IDW        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*DWIDTH-1:0] reqData,
    input  logic [NUM_REQ-1:0]        reqLast,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic [CRC_WIDTH-1:0]      genPoly,
    input  logic [CRC_WIDTH-1:0]      initValue,
    input  logic                      refInEn,
    input  logic                      refOutEn,
    input  logic [CRC_WIDTH-1:0]      finalXorValue,
    output logic                      resValid,
    input  logic                      resReady,
    output logic [CRC_WIDTH-1:0]      resCrc,
    output logic [REQ_IDW-1:0]        resId,
    output logic                      resErr,
    output logic                      busy,
    output sched_state_e              fsm_state
);

    // Handshakes: a word moves when reqValid[r] & reqReady[r] at a rising clk;
    // a result is retired when resValid & resReady; resValid holds until then.

    if (REQ_IDW != $clog2(NUM_REQ) || (DWIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("crc_frame_scheduler: inconsistent parameters");
    end

    sched_state_e         state_q, state_d;
    logic [REQ_IDW-1:0]   ptr_q, grant_q, arb_id;
    logic                 arb_found;
    logic [NUM_REQ-1:0]   rot;
    logic [CRC_WIDTH-1:0] poly_q, xor_q, crc_q, crc_next;
    logic                 ref_in_q, ref_out_q, err_q;
    logic [DWIDTH-1:0]    word_sel, word_in;
    logic                 valid_sel, last_sel, accept, tmo_hit;

    // Rotate so bit 0 is the requester just after the pointer; lowest set bit wins.
    always_comb begin
        int off;
        int sum;
        rot       = NUM_REQ'({reqValid, reqValid} >> (int'(ptr_q) + 1));
        arb_found = 1'b0;
        off       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                arb_found = 1'b1;
                off       = i;
            end
        end
        sum = int'(ptr_q) + 1 + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        arb_id = REQ_IDW'(sum);
    end

    always_comb begin
        word_sel  = '0;
        valid_sel = 1'b0;
        last_sel  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_q == REQ_IDW'(r)) begin
                word_sel  = reqData[r*DWIDTH +: DWIDTH];
                valid_sel = reqValid[r];
                last_sel  = reqLast[r];
            end
        end
    end

    assign accept  = (state_q == RUN) && valid_sel;
    assign word_in = ref_in_q ? DWIDTH'(byte_reflect(MAX_DW'(word_sel))) : word_sel;

    crc_word_step #(
        .CRC_WIDTH(CRC_WIDTH),
        .DWIDTH   (DWIDTH)
    ) u_step (
        .crcIn (crc_q),
        .data  (word_in),
        .poly  (poly_q),
        .crcOut(crc_next)
    );

`ifdef CRC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive stall cycle of a frame.
    assign tmo_hit = (state_q == RUN) && !accept && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tmo_q <= '0;
        end else if (state_q != RUN || accept) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_found) state_d = RUN;
            RUN:     if ((accept && last_sel) || tmo_hit) state_d = DONE;
            DONE:    if (resReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            ptr_q     <= REQ_IDW'(NUM_REQ - 1);
            grant_q   <= '0;
            poly_q    <= CRC_WIDTH'(DEFAULT_POLY);
            xor_q     <= '0;
            crc_q     <= '0;
            ref_in_q  <= 1'b0;
            ref_out_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        grant_q   <= arb_id;
                        poly_q    <= genPoly;
                        xor_q     <= finalXorValue;
                        ref_in_q  <= refInEn;
                        ref_out_q <= refOutEn;
                        crc_q     <= initValue;
                        err_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) crc_q <= crc_next;
                    if (tmo_hit) err_q <= 1'b1;
                end
                DONE: begin
                    if (resReady) ptr_q <= grant_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reqReady = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (state_q == RUN && grant_q == REQ_IDW'(r)) reqReady[r] = 1'b1;
        end
    end

    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;
    assign resValid  = (state_q == DONE);
    assign resId     = resValid ? grant_q : '0;
    assign resErr    = resValid && err_q;
    assign resCrc    = (!resValid || err_q) ? '0 :
                       ((ref_out_q ? CRC_WIDTH'(bit_reverse(MAX_CW'(crc_q), CRC_WIDTH)) : crc_q) ^ xor_q);

endmodule

// File: tb/tb_crc_frame_scheduler.sv
// Self-checking bench for crc_frame_scheduler against a bit-serial frame-level CRC model.
module tb_crc_frame_scheduler;
    import crc_sched_pkg::*;

    localparam int NR  = 4;
    localparam int CW  = 16;
    localparam int DW  = 32;
    localparam int IDW = 2;
    localparam int TMO = 8;

    logic              clk;
    logic              rstN;
    logic [NR-1:0]     reqValid;
    logic [NR*DW-1:0]  reqData;
    logic [NR-1:0]     reqLast;
    logic [NR-1:0]     reqReady;
    logic [CW-1:0]     genPoly;
    logic [CW-1:0]     initValue;
    logic              refInEn;
    logic              refOutEn;
    logic [CW-1:0]     finalXorValue;
    logic              resValid;
    logic              resReady;
    logic [CW-1:0]     resCrc;
    logic [IDW-1:0]    resId;
    logic              resErr;
    logic              busy;
    sched_state_e      fsm_state;

    int checks   = 0;
    int failures = 0;
    logic [IDW+CW-1:0] exp_q[$];

    crc_frame_scheduler #(
        .NUM_REQ(NR), .CRC_WIDTH(CW), .DWIDTH(DW), .REQ_IDW(IDW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
        .reqReady(reqReady), .genPoly(genPoly), .initValue(initValue), .refInEn(refInEn),
        .refOutEn(refOutEn), .finalXorValue(finalXorValue), .resValid(resValid),
        .resReady(resReady), .resCrc(resCrc), .resId(resId), .resErr(resErr), .busy(busy),
        .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Frame CRC as a serial bit stream: bytes high-to-low, bits LSB-first when reflecting.
    function automatic logic [CW-1:0] model_crc(input logic [DW-1:0] words[$], input logic [CW-1:0] poly,
                                                input logic [CW-1:0] init, input bit refin, input bit refout,
                                                input logic [CW-1:0] xorv);
        bit bits[$];
        logic [CW-1:0] c, r;
        bit top;
        foreach (words[w]) begin
            for (int b = DW / 8 - 1; b >= 0; b--) begin
                for (int k = 0; k < 8; k++) begin
                    bits.push_back(refin ? words[w][b*8+k] : words[w][b*8+7-k]);
                end
            end
        end
        c = init;
        foreach (bits[j]) begin
            top = c[CW-1];
            c   = c << 1;
            if (top ^ bits[j]) c = c ^ poly;
        end
        if (refout) begin
            for (int i = 0; i < CW; i++) r[i] = c[CW-1-i];
            c = r;
        end
        return c ^ xorv;
    endfunction

    task automatic do_reset();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input int r, input logic [DW-1:0] w, input bit last);
        int n;
        n = 0;
        reqValid[r] = 1'b1;
        reqData[r*DW +: DW] = w;
        reqLast[r] = last;
        @(negedge clk);
        while (!reqReady[r] && n < 300) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (reqReady[r] !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait req=%0d got_ready=%b want=1", r, reqReady[r]);
        end
        @(posedge clk);
        #1;
        reqValid[r] = 1'b0;
        reqLast[r]  = 1'b0;
    endtask

    task automatic send_frame(input int r, input logic [DW-1:0] words[$], input int gap);
        for (int i = 0; i < words.size(); i++) begin
            drive_word(r, words[i], i == words.size() - 1);
            if (i < words.size() - 1 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic get_result(output logic [CW-1:0] crc, output logic [IDW-1:0] id, output logic err);
        int n;
        n = 0;
        @(negedge clk);
        while (!resValid && n < 300) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (resValid !== 1'b1) begin
            failures++;
            $display("FAIL result_wait got_valid=%b want=1", resValid);
        end
        crc = resCrc;
        id  = resId;
        err = resErr;
        resReady = 1'b1;
        @(posedge clk);
        #1;
        resReady = 1'b0;
    endtask

    task automatic set_cfg(input logic [CW-1:0] p, input logic [CW-1:0] i, input bit ri, input bit ro,
                           input logic [CW-1:0] x);
        genPoly = p; initValue = i; refInEn = ri; refOutEn = ro; finalXorValue = x;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        #1;
        checks++;
        if ({reqReady, resValid, resCrc, resId, resErr, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {reqReady, resValid, resCrc, resId, resErr, busy});
        end
        checks++;
        if (fsm_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d want=%0d", fsm_state, IDLE);
        end
        do_reset();
    endtask

    task automatic test_directed();
        logic [DW-1:0] w_tab[4]   = '{32'h1, 32'h1, 32'h0, 32'h80};
        bit            ri_tab[4]  = '{0, 0, 0, 1};
        bit            ro_tab[4]  = '{0, 1, 0, 0};
        logic [CW-1:0] x_tab[4]   = '{16'h0, 16'h0, 16'hFFFF, 16'h0};
        logic [CW-1:0] exp_tab[4] = '{16'h1021, 16'h8408, 16'hFFFF, 16'h1021};
        logic [CW-1:0] crc;
        logic [IDW-1:0] id;
        logic err;
        for (int t = 0; t < 4; t++) begin
            set_cfg(16'h1021, 16'h0, ri_tab[t], ro_tab[t], x_tab[t]);
            drive_word(0, w_tab[t], 1'b1);
            @(negedge clk);
            checks++;
            if (resValid !== 1'b1) begin
                failures++;
                $display("FAIL directed_latency case=%0d got_valid=%b want=1", t, resValid);
            end
            get_result(crc, id, err);
            checks++;
            if (crc !== exp_tab[t] || id !== 2'd0 || err !== 1'b0) begin
                failures++;
                $display("FAIL directed_crc case=%0d got=%h/%0d/%b want=%h/0/0", t, crc, id, err, exp_tab[t]);
            end
        end
    endtask

    task automatic test_bubble();
        logic [CW-1:0] crc;
        logic [IDW-1:0] id;
        logic err;
        set_cfg(16'h1021, 16'h0, 0, 0, 16'h0);
        drive_word(0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (reqReady !== 4'b0001) begin
                failures++;
                $display("FAIL bubble_ready cycle=%0d got=%b want=0001", k, reqReady);
            end
            @(posedge clk);
        end
        #1;
        drive_word(0, 32'h1, 1'b1);
        get_result(crc, id, err);
        checks++;
        if (crc !== 16'h1021 || id !== 2'd0) begin
            failures++;
            $display("FAIL bubble_crc got=%h/%0d want=1021/0", crc, id);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] words[$];
        logic [CW-1:0] p, iv, x, exp_crc, crc;
        logic [IDW-1:0] id;
        logic err;
        bit ri, ro;
        int r, len, gap;
        for (int f = 0; f < 24; f++) begin
            words.delete();
            r   = $urandom_range(0, NR - 1);
            len = $urandom_range(1, 4);
            gap = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) words.push_back(DW'($urandom));
            p  = CW'($urandom);
            iv = CW'($urandom);
            x  = CW'($urandom);
            ri = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            set_cfg(p, iv, ri, ro, x);
            exp_crc = model_crc(words, p, iv, ri, ro, x);
            fork
                send_frame(r, words, gap);
            join_none
            repeat (2) @(posedge clk);
            #1;
            set_cfg(CW'($urandom), CW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), CW'($urandom));
            get_result(crc, id, err);
            wait fork;
            checks++;
            if (crc !== exp_crc || id !== IDW'(r) || err !== 1'b0) begin
                failures++;
                $display("FAIL random_frame n=%0d got=%h/%0d/%b want=%h/%0d/0", f, crc, id, err, exp_crc, r);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] a[$], b[$], c[$];
        logic [CW-1:0] crc;
        logic [IDW-1:0] id;
        logic err;
        logic [IDW+CW-1:0] e;
        set_cfg(16'h8005, 16'hFFFF, 0, 0, 16'h0);
        do_reset();
        a.push_back(DW'($urandom));
        b.push_back(DW'($urandom));
        c.push_back(DW'($urandom));
        exp_q.push_back({2'd0, model_crc(a, 16'h8005, 16'hFFFF, 0, 0, 16'h0)});
        exp_q.push_back({2'd2, model_crc(c, 16'h8005, 16'hFFFF, 0, 0, 16'h0)});
        exp_q.push_back({2'd0, model_crc(b, 16'h8005, 16'hFFFF, 0, 0, 16'h0)});
        fork
            begin
                send_frame(0, a, 0);
                send_frame(0, b, 0);
            end
            send_frame(2, c, 0);
        join_none
        for (int k = 0; k < 3; k++) begin
            get_result(crc, id, err);
            e = exp_q.pop_front();
            checks++;
            if ({id, crc} !== e) begin
                failures++;
                $display("FAIL rr_order slot=%0d got=%0d/%h want=%0d/%h", k, id, crc, e[IDW+CW-1:CW], e[CW-1:0]);
            end
        end
        wait fork;
    endtask

    task automatic test_hold();
        logic [DW-1:0] x[$], y[$];
        logic [CW-1:0] crc, exp_x, exp_y;
        logic [IDW-1:0] id;
        logic err;
        int n;
        set_cfg(16'h1021, 16'h1D0F, 1, 1, 16'h00FF);
        do_reset();
        x.push_back(DW'($urandom));
        x.push_back(DW'($urandom));
        y.push_back(DW'($urandom));
        exp_x = model_crc(x, 16'h1021, 16'h1D0F, 1, 1, 16'h00FF);
        exp_y = model_crc(y, 16'h1021, 16'h1D0F, 1, 1, 16'h00FF);
        fork
            send_frame(1, x, 0);
            send_frame(3, y, 0);
        join_none
        n = 0;
        @(negedge clk);
        while (!resValid && n < 300) begin
            n++;
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (resValid !== 1'b1 || resCrc !== exp_x || resId !== 2'd1 || reqReady !== '0 || fsm_state !== DONE) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d got=%b/%h/%0d/%b want=1/%h/1/0000", k, resValid, resCrc,
                         resId, reqReady, exp_x);
            end
            @(negedge clk);
        end
        get_result(crc, id, err);
        get_result(crc, id, err);
        wait fork;
        checks++;
        if (crc !== exp_y || id !== 2'd3) begin
            failures++;
            $display("FAIL hold_next got=%h/%0d want=%h/3", crc, id, exp_y);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w[$];
        logic [CW-1:0] crc, exp_crc;
        logic [IDW-1:0] id;
        logic err;
        set_cfg(16'h1021, 16'h0, 0, 0, 16'h0);
        drive_word(0, 32'hDEADBEEF, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if ({reqReady, resValid, resCrc, resId, resErr, busy} !== '0 || fsm_state !== IDLE) begin
            failures++;
            $display("FAIL midreset_outputs got=%h/%0d want=0/%0d",
                     {reqReady, resValid, resCrc, resId, resErr, busy}, fsm_state, IDLE);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        w.push_back(32'h1);
        exp_crc = model_crc(w, 16'h1021, 16'h0, 0, 0, 16'h0);
        send_frame(0, w, 0);
        get_result(crc, id, err);
        checks++;
        if (crc !== exp_crc || id !== 2'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_restart got=%h/%0d/%b want=%h/0/0", crc, id, err, exp_crc);
        end
    endtask

`ifdef CRC_TIMEOUT_EN
    task automatic test_timeout();
        logic [CW-1:0] crc;
        logic [IDW-1:0] id;
        logic err;
        bit early;
        early = 1'b0;
        drive_word(1, 32'h12345678, 1'b0);
        repeat (TMO) begin
            @(negedge clk);
            if (resValid) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL timeout_early got_early=1 want=0");
        end
        get_result(crc, id, err);
        checks++;
        if (err !== 1'b1 || crc !== '0 || id !== 2'd1) begin
            failures++;
            $display("FAIL timeout_result got=%b/%h/%0d want=1/0000/1", err, crc, id);
        end
    endtask
`endif

    initial begin
        rstN = 1'b0;
        reqValid = '0;
        reqData = '0;
        reqLast = '0;
        resReady = 1'b0;
        set_cfg(16'h1021, 16'h0, 0, 0, 16'h0);
        test_reset();
        test_directed();
        test_bubble();
        test_random();
        test_round_robin();
        test_hold();
        test_reset_mid();
`ifdef CRC_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
